// File: rtl/vote_result_reader.sv
// vote_result_reader: drives a 4-candidate voting machine through result display, streams
// one (candidate, tally) record per candidate and reports the winner. Option macro: VOTE_TOTAL_EN.
`default_nettype none

module vote_result_reader #(
   parameter int SETTLE_CYCLES = 4,
   parameter int NUM_CAND      = 4
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       start,
   output logic       vm_mode,
   output logic       vm_button1,
   output logic       vm_button2,
   output logic       vm_button3,
   output logic       vm_button4,
   input  logic [7:0] vm_led,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [1:0] out_cand,
   output logic [7:0] out_count,
   output logic       busy,
   output logic       done,
   output logic [1:0] winner_id,
   output logic [7:0] winner_count
`ifdef VOTE_TOTAL_EN
   ,
   output logic [9:0] total_count,
   output logic       total_valid
`endif
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      SELECT = 3'd1,
      SEND   = 3'd2,
      GAP    = 3'd3,
      REPORT = 3'd4
   } state_t;

   localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
   localparam logic [1:0] LAST_IDX    = 2'(NUM_CAND - 1);

   state_t     state;
   state_t     state_next;
   logic [1:0] idx;
   logic [7:0] settle_cnt;
   logic       settle_done;
   logic       handshake;
   logic       last_cand;
   logic       total_pending;
`ifdef VOTE_TOTAL_EN
   logic       total_phase;
`endif

   always_ff @(posedge clock) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   always_comb begin
      settle_done = (state == SELECT) && (settle_cnt == SETTLE_LAST);
      handshake   = (state == SEND) && out_ready;
      last_cand   = (idx == LAST_IDX);
`ifdef VOTE_TOTAL_EN
      // The summary record follows the last candidate's record in the same SEND state.
      total_pending = last_cand && !total_phase;
      total_valid   = (state == SEND) && total_phase;
`else
      total_pending = 1'b0;
`endif
      state_next = state;
      case (state)
         IDLE:    if (start) state_next = SELECT;
         SELECT:  if (settle_done) state_next = SEND;
         SEND: begin
            if (handshake) begin
               if (!last_cand)          state_next = GAP;
               else if (!total_pending) state_next = REPORT;
            end
         end
         GAP:     state_next = SELECT;
         REPORT:  state_next = IDLE;
         default: state_next = IDLE;
      endcase

      vm_mode    = (state != IDLE);
      busy       = (state != IDLE);
      out_valid  = (state == SEND);
      done       = (state == REPORT);
      vm_button1 = (state == SELECT) && (idx == 2'd0);
      vm_button2 = (state == SELECT) && (idx == 2'd1);
      vm_button3 = (state == SELECT) && (idx == 2'd2);
      vm_button4 = (state == SELECT) && (idx == 2'd3);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         idx          <= 2'd0;
         settle_cnt   <= 8'd0;
         out_cand     <= 2'd0;
         out_count    <= 8'd0;
         winner_id    <= 2'd0;
         winner_count <= 8'd0;
`ifdef VOTE_TOTAL_EN
         total_count  <= 10'd0;
         total_phase  <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  idx          <= 2'd0;
                  settle_cnt   <= 8'd0;
                  winner_id    <= 2'd0;
                  winner_count <= 8'd0;
`ifdef VOTE_TOTAL_EN
                  total_count  <= 10'd0;
                  total_phase  <= 1'b0;
`endif
               end
            end
            SELECT: begin
               if (settle_done) begin
                  out_count <= vm_led;
                  out_cand  <= idx;
                  // Strict compare keeps ties on the lowest index.
                  if ((idx == 2'd0) || (vm_led > winner_count)) begin
                     winner_id    <= idx;
                     winner_count <= vm_led;
                  end
`ifdef VOTE_TOTAL_EN
                  total_count <= total_count + {2'b00, vm_led};
`endif
               end else begin
                  settle_cnt <= settle_cnt + 8'd1;
               end
            end
            SEND: begin
`ifdef VOTE_TOTAL_EN
               if (handshake && total_pending) begin
                  total_phase <= 1'b1;
                  out_cand    <= 2'd0;
                  out_count   <= total_count[7:0];
               end
`endif
            end
            GAP: begin
               idx        <= idx + 2'd1;
               settle_cnt <= 8'd0;
            end
            default: ;
         endcase
      end
   end

   a_buttons_onehot : assert property (@(posedge clock) disable iff (reset)
      $onehot0({vm_button4, vm_button3, vm_button2, vm_button1}) &&
      (vm_mode || ({vm_button4, vm_button3, vm_button2, vm_button1} == 4'b0000)));

endmodule

`default_nettype wire

// File: tb/tb_vote_result_reader.sv
// Directed bench for vote_result_reader with a behavioural voting-machine tally model.
`default_nettype none

module tb_vote_result_reader;
   localparam int SETTLE = 4;
`ifdef VOTE_TOTAL_EN
   localparam int EXTRA = 1;
`else
   localparam int EXTRA = 0;
`endif
   localparam int NREC = 4 + EXTRA;

   logic       clock = 1'b0;
   logic       reset;
   logic       start;
   logic       vm_mode;
   logic       b1, b2, b3, b4;
   logic [7:0] vm_led;
   logic       out_valid;
   logic       out_ready;
   logic [1:0] out_cand;
   logic [7:0] out_count;
   logic       busy;
   logic       done;
   logic [1:0] winner_id;
   logic [7:0] winner_count;
`ifdef VOTE_TOTAL_EN
   logic [9:0] total_count;
   logic       total_valid;
`endif

   logic [7:0] tally [4];
   int         n_checks = 0;
   int         n_errors = 0;
   logic [27:0] all_out;

   vote_result_reader #(.SETTLE_CYCLES(SETTLE), .NUM_CAND(4)) dut (
      .clock(clock), .reset(reset), .start(start),
      .vm_mode(vm_mode), .vm_button1(b1), .vm_button2(b2), .vm_button3(b3), .vm_button4(b4),
      .vm_led(vm_led), .out_valid(out_valid), .out_ready(out_ready),
      .out_cand(out_cand), .out_count(out_count), .busy(busy), .done(done),
      .winner_id(winner_id), .winner_count(winner_count)
`ifdef VOTE_TOTAL_EN
      , .total_count(total_count), .total_valid(total_valid)
`endif
   );

   always #5 clock = ~clock;

   // Machine model: led shows the tally of the pressed button in result mode.
   always_comb begin
      vm_led = 8'd0;
      if (vm_mode) begin
         if (b1) vm_led = tally[0];
         if (b2) vm_led = tally[1];
         if (b3) vm_led = tally[2];
         if (b4) vm_led = tally[3];
      end
   end

   assign all_out = {vm_mode, b4, b3, b2, b1, out_valid, out_cand, out_count,
                     busy, done, winner_id, winner_count};

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic run_readout(input int stall_rec, input int stall_len, input bit spam,
                              input logic [1:0] exp_id, input logic [7:0] exp_cnt);
      int         cyc = 1, recs = 0, stalled = 0, run_on = 0, run_off = 0;
      int         presses = 0, dones = 0, done_cyc = 0;
      logic [3:0] btn;
      logic [3:0] prev = 4'b0000;
      logic [1:0] hold_cand = 2'd0;
      logic [7:0] hold_cnt = 8'd0;
      bit         holding = 1'b0;
`ifdef VOTE_TOTAL_EN
      logic [9:0] sum = {2'b00, tally[0]} + {2'b00, tally[1]} + {2'b00, tally[2]} + {2'b00, tally[3]};
`endif
      @(negedge clock);
      start     = 1'b1;
      out_ready = 1'b1;
      while (dones == 0 && cyc < 400) begin
         @(negedge clock);
         cyc++;
         btn = {b4, b3, b2, b1};
         check("btn_onehot", {31'd0, $onehot0(btn) && (vm_mode || btn == 4'b0000)}, 32'd1);
         if (btn != 4'b0000 && prev == 4'b0000) begin
            check("press_idx", {28'd0, btn}, 32'd1 << presses);
            if (presses > 0)
               check("gap_len", run_off, 2 + (((presses - 1) == stall_rec) ? stall_len : 0));
            presses++;
            run_on = 1;
         end else if (btn != 4'b0000) begin
            run_on++;
         end
         if (btn == 4'b0000 && prev != 4'b0000) begin
            check("press_len", run_on, SETTLE);
            run_off = 1;
         end else if (btn == 4'b0000) begin
            run_off++;
         end
         prev = btn;

         if (out_valid) begin
            check("send_btn_zero", {28'd0, btn}, 32'd0);
            if (holding) begin
               check("stable_cand", out_cand, hold_cand);
               check("stable_count", out_count, hold_cnt);
            end else begin
               holding   = 1'b1;
               hold_cand = out_cand;
               hold_cnt  = out_count;
            end
            out_ready = !(recs == stall_rec && stalled < stall_len);
            if (!out_ready) stalled++;
            else begin
               if (recs < 4) begin
                  check("rec_cand", out_cand, recs);
                  check("rec_count", out_count, tally[recs]);
               end
`ifdef VOTE_TOTAL_EN
               else begin
                  check("tot_cand", out_cand, 0);
                  check("tot_count", out_count, sum[7:0]);
                  check("tot_valid", total_valid, 1);
               end
`endif
               recs++;
               holding = 1'b0;
            end
         end else begin
            out_ready = 1'b1;
         end

         if (done) begin
            dones++;
            done_cyc = cyc;
            check("winner_id", winner_id, exp_id);
            check("winner_count", winner_count, exp_cnt);
         end
         start = spam && !done;
      end
      start     = 1'b0;
      out_ready = 1'b1;
      check("done_seen", dones, 1);
      check("done_cycle", done_cyc, 4 * (SETTLE + 1) + 5 + stall_len + EXTRA);
      check("rec_total", recs, NREC);
      repeat (5) begin
         @(negedge clock);
         if (done) dones++;
      end
      check("done_once", dones, 1);
      check("idle_busy_mode", {busy, vm_mode}, 2'b00);
      check("winner_hold", {winner_id, winner_count}, {exp_id, exp_cnt});
   endtask

   initial begin
      reset     = 1'b1;
      start     = 1'b0;
      out_ready = 1'b1;
      tally     = '{8'd0, 8'd0, 8'd0, 8'd0};
      repeat (3) @(negedge clock);
      check("reset_outputs", all_out, 28'd0);
      reset = 1'b0;

      tally = '{8'd2, 8'd2, 8'd2, 8'd2};
      run_readout(-1, 0, 1'b0, 2'd0, 8'd2);

      tally = '{8'd5, 8'd9, 8'd9, 8'd3};
      run_readout(-1, 0, 1'b0, 2'd1, 8'd9);

      tally = '{8'd7, 8'd1, 8'd8, 8'd8};
      run_readout(2, 7, 1'b0, 2'd2, 8'd8);

      // Abort during candidate 1's settle window.
      tally = '{8'd3, 8'd4, 8'd5, 8'd6};
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      repeat (7) @(negedge clock);
      check("pre_reset_btn2", {b4, b3, b2, b1}, 4'b0010);
      reset = 1'b1;
      @(negedge clock);
      check("mid_reset_outputs", all_out, 28'd0);
      reset = 1'b0;
      tally = '{8'd4, 8'd6, 8'd1, 8'd6};
      run_readout(-1, 0, 1'b0, 2'd1, 8'd6);

      tally = '{8'd0, 8'd0, 8'd0, 8'd1};
      run_readout(-1, 0, 1'b1, 2'd3, 8'd1);

`ifdef VOTE_TOTAL_EN
      tally = '{8'd255, 8'd255, 8'd255, 8'd255};
      run_readout(-1, 0, 1'b0, 2'd0, 8'd255);
      check("total_count", total_count, 10'd1020);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire
